// File: rtl/pmp_pkg.sv
// rtl/pmp_pkg.sv - shared PMP mode codes, privilege code and checker FSM states
`ifndef PA_BITS
`define PA_BITS 34
`endif

package pmp_pkg;
    localparam int PA_BITS = `PA_BITS;

    localparam logic [1:0] A_OFF   = 2'b00;
    localparam logic [1:0] A_TOR   = 2'b01;
    localparam logic [1:0] A_NA4   = 2'b10;
    localparam logic [1:0] A_NAPOT = 2'b11;

    localparam logic [1:0] PRIV_M = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } chk_state_e;
endpackage

// File: rtl/pmpadrdec.sv
// rtl/pmpadrdec.sv - single PMP entry address decoder (TOR / NA4 / NAPOT)
module pmpadrdec
    import pmp_pkg::*;
(
    input  logic [PA_BITS-1:0] PhysicalAddress,
    input  logic [1:0]         Size,
    input  logic [7:0]         PMPCfg,
    input  logic [PA_BITS-3:0] PMPAdr,
    input  logic               PAgePMPAdrIn,
    input  logic               TORCrossPrevIn,
    output logic               PAgePMPAdrOut,
    output logic               TORCrossPrevOut,
    output logic               Match,
    output logic               AllBytesMatch,
    output logic               L,
    output logic               X,
    output logic               W,
    output logic               R
);
    localparam logic [PA_BITS:0]   ONE     = {{PA_BITS{1'b0}}, 1'b1};
    localparam logic [PA_BITS-3:0] ADR_ONE = {{(PA_BITS-3){1'b0}}, 1'b1};

    logic [1:0]         a_mode;
    logic [PA_BITS:0]   pa_lo;
    logic [PA_BITS:0]   pa_hi;
    logic [PA_BITS:0]   bound;
    logic [PA_BITS-3:0] adr_mask;
    logic [PA_BITS-1:0] napot_mask;
    logic [PA_BITS:0]   region_lo;
    logic [PA_BITS:0]   region_hi;
    logic               unused_cfg_bits;

    assign a_mode = PMPCfg[4:3];
    assign unused_cfg_bits = ^PMPCfg[6:5];

    // One extra bit so the last byte of an access at the top of memory cannot wrap.
    assign pa_lo = {1'b0, PhysicalAddress};
    assign pa_hi = pa_lo + (ONE << Size) - ONE;

    // This entry's address is the lower bound of the next entry when that one is TOR.
    assign bound           = {1'b0, PMPAdr, 2'b00};
    assign PAgePMPAdrOut   = (pa_lo >= bound);
    assign TORCrossPrevOut = (pa_lo < bound) && (pa_hi >= bound);

    // Trailing ones of a NAPOT address plus the first zero are don't-care bits.
    assign adr_mask   = (a_mode == A_NAPOT) ? (PMPAdr ^ (PMPAdr + ADR_ONE)) : '0;
    assign napot_mask = {adr_mask, 2'b11};
    assign region_lo  = {1'b0, {PMPAdr, 2'b00} & ~napot_mask};
    assign region_hi  = {1'b0, {PMPAdr, 2'b00} | napot_mask};

    always_comb begin
        Match         = 1'b0;
        AllBytesMatch = 1'b0;
        unique case (a_mode)
            A_TOR: begin
                Match         = (PAgePMPAdrIn | TORCrossPrevIn) & ~PAgePMPAdrOut;
                AllBytesMatch = PAgePMPAdrIn & (pa_hi < bound);
            end
            A_NA4, A_NAPOT: begin
                Match         = (pa_lo <= region_hi) & (pa_hi >= region_lo);
                AllBytesMatch = (pa_lo >= region_lo) & (pa_hi <= region_hi);
            end
            default: ;
        endcase
    end

    assign L = PMPCfg[7];
    assign X = PMPCfg[2];
    assign W = PMPCfg[1];
    assign R = PMPCfg[0];
endmodule

// File: rtl/pmp_serial_checker.sv
// rtl/pmp_serial_checker.sv - PMP checker scanning one entry per cycle through a shared decoder
module pmp_serial_checker
    import pmp_pkg::*;
#(
    parameter int PMP_ENTRIES = 16,
    localparam int IDX_W = (PMP_ENTRIES > 1) ? $clog2(PMP_ENTRIES) : 1
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                ReqValid,
    output logic                                ReqReady,
    input  logic [PA_BITS-1:0]                  PhysicalAddress,
    input  logic [1:0]                          Size,
    input  logic                                ExecuteAccess,
    input  logic                                WriteAccess,
    input  logic                                ReadAccess,
    input  logic [1:0]                          PrivilegeMode,
    input  logic [PMP_ENTRIES-1:0][7:0]         PMPCfg,
    input  logic [PMP_ENTRIES-1:0][PA_BITS-3:0] PMPAdr,
    input  logic                                Flush,
    output logic                                RspValid,
    input  logic                                RspReady,
    output logic                                PMPInstrAccessFault,
    output logic                                PMPLoadAccessFault,
    output logic                                PMPStoreAmoAccessFault,
    output logic                                MatchValid,
    output logic [IDX_W-1:0]                    MatchIndex
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PMP_ENTRIES - 1);

    chk_state_e         state_q;
    logic [IDX_W-1:0]   idx_q;
    logic               page_q, cross_q;
    logic [PA_BITS-1:0] addr_q;
    logic [1:0]         size_q, priv_q;
    logic               x_q, w_q, r_q;
    logic               any_on_q;
    logic               hit_q, hit_all_q, hit_l_q, hit_x_q, hit_w_q, hit_r_q;
    logic               rsp_valid_q, match_valid_q;
    logic [IDX_W-1:0]   match_index_q;
    logic               ifault_q, lfault_q, sfault_q;
    logic               ifault_d, lfault_d, sfault_d;

    logic [7:0]         cur_cfg;
    logic [PA_BITS-3:0] cur_adr;
    logic               dec_page, dec_cross, dec_match, dec_all;
    logic               dec_l, dec_x, dec_w, dec_r;
    logic               enforce, deny_nomatch;

    assign cur_cfg = PMPCfg[idx_q];
    assign cur_adr = PMPAdr[idx_q];

    pmpadrdec u_pmpadrdec (
        .PhysicalAddress (addr_q),
        .Size            (size_q),
        .PMPCfg          (cur_cfg),
        .PMPAdr          (cur_adr),
        .PAgePMPAdrIn    (page_q),
        .TORCrossPrevIn  (cross_q),
        .PAgePMPAdrOut   (dec_page),
        .TORCrossPrevOut (dec_cross),
        .Match           (dec_match),
        .AllBytesMatch   (dec_all),
        .L               (dec_l),
        .X               (dec_x),
        .W               (dec_w),
        .R               (dec_r)
    );

    // Faults are resolved from the latched scan outcome in the first DONE cycle.
    always_comb begin
        enforce      = hit_l_q | (priv_q != PRIV_M);
        deny_nomatch = (priv_q != PRIV_M) & any_on_q;
        ifault_d     = 1'b0;
        lfault_d     = 1'b0;
        sfault_d     = 1'b0;
        if (hit_q) begin
            ifault_d = x_q & enforce & (~hit_all_q | ~hit_x_q);
            sfault_d = w_q & enforce & (~hit_all_q | ~hit_w_q);
            lfault_d = r_q & enforce & (~hit_all_q | ~hit_r_q);
        end else begin
            ifault_d = x_q & deny_nomatch;
            sfault_d = w_q & deny_nomatch;
            lfault_d = r_q & deny_nomatch;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            page_q        <= 1'b0;
            cross_q       <= 1'b0;
            addr_q        <= '0;
            size_q        <= 2'b00;
            priv_q        <= 2'b00;
            x_q           <= 1'b0;
            w_q           <= 1'b0;
            r_q           <= 1'b0;
            any_on_q      <= 1'b0;
            hit_q         <= 1'b0;
            hit_all_q     <= 1'b0;
            hit_l_q       <= 1'b0;
            hit_x_q       <= 1'b0;
            hit_w_q       <= 1'b0;
            hit_r_q       <= 1'b0;
            rsp_valid_q   <= 1'b0;
            match_valid_q <= 1'b0;
            match_index_q <= '0;
            ifault_q      <= 1'b0;
            lfault_q      <= 1'b0;
            sfault_q      <= 1'b0;
        end else if (Flush) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ReqValid) begin
                        addr_q   <= PhysicalAddress;
                        size_q   <= Size;
                        priv_q   <= PrivilegeMode;
                        x_q      <= ExecuteAccess;
                        w_q      <= WriteAccess;
                        r_q      <= ReadAccess;
                        idx_q    <= '0;
                        page_q   <= 1'b1;
                        cross_q  <= 1'b0;
                        any_on_q <= 1'b0;
                        hit_q    <= 1'b0;
                        state_q  <= SCAN;
                    end
                end
                SCAN: begin
                    any_on_q <= any_on_q | (cur_cfg[4:3] != A_OFF);
                    if (dec_match) begin
                        hit_q     <= 1'b1;
                        hit_all_q <= dec_all;
                        hit_l_q   <= dec_l;
                        hit_x_q   <= dec_x;
                        hit_w_q   <= dec_w;
                        hit_r_q   <= dec_r;
                        state_q   <= DONE;
                    end else begin
                        page_q  <= dec_page;
                        cross_q <= dec_cross;
                        if (idx_q == LAST_IDX) begin
                            state_q <= DONE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!rsp_valid_q) begin
                        rsp_valid_q   <= 1'b1;
                        match_valid_q <= hit_q;
                        match_index_q <= hit_q ? idx_q : '0;
                        ifault_q      <= ifault_d;
                        lfault_q      <= lfault_d;
                        sfault_q      <= sfault_d;
                    end else if (RspReady) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ReqReady               = (state_q == IDLE);
    assign RspValid               = rsp_valid_q;
    assign MatchValid             = match_valid_q;
    assign MatchIndex             = match_index_q;
    assign PMPInstrAccessFault    = ifault_q;
    assign PMPLoadAccessFault     = lfault_q;
    assign PMPStoreAmoAccessFault = sfault_q;
endmodule

// File: doc/pmp_serial_checker.md
PMP_SERIAL_CHECKER -- requirements
Module: pmp_serial_checker

Interface
REQ-001 SHALL have parameter PMP_ENTRIES, default 16, giving the number of PMP entries scanned (legal 1..64).
REQ-002 SHALL size physical addresses by the configuration macro PA_BITS.
REQ-003 SHALL have port clk, input, 1 bit, the single clock.
REQ-004 SHALL have port reset_n, input, 1 bit, a synchronous, active-low reset.
REQ-005 SHALL have port ReqValid, input, 1 bit, request present.
REQ-006 SHALL have port ReqReady, output, 1 bit, request accepted this cycle when high together with ReqValid.
REQ-007 SHALL have port PhysicalAddress, input, PA_BITS bits, access address.
REQ-008 SHALL have port Size, input, 2 bits, log2 of the access bytes.
REQ-009 SHALL have ports ExecuteAccess, WriteAccess and ReadAccess, each input, 1 bit, giving the access type.
REQ-010 SHALL have port PrivilegeMode, input, 2 bits, where 2'b11 denotes M-mode.
REQ-011 SHALL have port PMPCfg, input, PMP_ENTRIES x 8 bits, per-entry configuration.
REQ-012 SHALL have port PMPAdr, input, PMP_ENTRIES x (PA_BITS-2) bits, per-entry address.
REQ-013 SHALL have port Flush, input, 1 bit, synchronous abort.
REQ-014 SHALL have port RspValid, output, 1 bit, result available.
REQ-015 SHALL have port RspReady, input, 1 bit, consumer takes the result.
REQ-016 SHALL have ports PMPInstrAccessFault, PMPLoadAccessFault and PMPStoreAmoAccessFault, each output, 1 bit, the fault results.
REQ-017 SHALL have port MatchValid, output, 1 bit, an entry matched.
REQ-018 SHALL have port MatchIndex, output, clog2(PMP_ENTRIES) bits, index of the matching entry.

Function
REQ-019 SHALL implement FSM states IDLE, SCAN and DONE.
REQ-020 SHALL drive ReqReady=1 only in IDLE.
REQ-021 SHALL, on ReqValid&ReqReady, register the address, size, type and privilege, set Idx=0, PAgeReg=1, CrossReg=0, and enter SCAN.
REQ-022 SHALL, in SCAN, evaluate exactly one entry per cycle, entry Idx, using the live PMPCfg[Idx]/PMPAdr[Idx] and PAgePMPAdrIn=PAgeReg, TORCrossPrevIn=CrossReg.
REQ-023 SHALL, on each SCAN cycle without a match, load PAgeReg with PAgePMPAdrOut and CrossReg with TORCrossPrevOut, and increment Idx.
REQ-024 SHALL give the lowest-numbered matching entry priority: on the first Match, latch the result, MatchValid=1, MatchIndex=Idx, and go to DONE.
REQ-025 SHALL, when Idx==PMP_ENTRIES-1 with no match, go to DONE with MatchValid=0.
REQ-026 SHALL, for a matched entry, enforce permissions when L=1 or PrivilegeMode!=M.
REQ-027 SHALL, for an enforced entry, fault a type when AllBytesMatch=0 or its permission bit is clear (Execute->X, Write->W, Read->R).
REQ-028 SHALL, on no match, fault every requested type iff PrivilegeMode!=M and any entry has a nonzero A field (PMPCfg[4:3]).
REQ-029 SHALL produce no fault when no access-type bit is set.
REQ-030 SHALL have latency as follows: with acceptance at edge t and a match on entry k, RspValid rises at edge t+k+2; a no-match result rises at edge t+PMP_ENTRIES+1.
REQ-031 SHALL, in DONE, hold RspValid=1 and all result outputs stable until RspReady=1, then return to IDLE.
REQ-032 SHALL NOT accept a new request in the same cycle that RspReady completes a response (no back-to-back bypass).
REQ-033 SHALL, on Flush=1 in any state, go to IDLE next cycle without producing a response; Flush takes priority over a simultaneous accept or match.
REQ-034 SHALL leave results undefined if PMPCfg/PMPAdr change during SCAN; the CSR side flushes on PMP writes.
REQ-035 SHALL hold Idx at PMP_ENTRIES-1 and never let it wrap.

Reset
REQ-036 SHALL, when reset_n=0 at a clk edge, enter IDLE, clear Idx, PAgeReg and CrossReg, and set RspValid, all faults, MatchValid and MatchIndex to 0.
REQ-037 SHALL, when reset is applied mid-SCAN or in DONE, discard the request with no response.
REQ-038 SHALL drive ReqReady=1 on the first cycle after reset_n deasserts.

Structure
REQ-039 SHALL place the TOR/NA4/NAPOT mode codes, the M-mode privilege code and the FSM state enum in a shared package, pmp_pkg.
REQ-040 SHALL instantiate exactly one pmpadrdec as a sub-module, multiplexed by Idx.
REQ-041 SHALL be implemented in 120-400 lines of RTL.

Verification
REQ-042 Bench SHALL show: entry 0 NAPOT region 0x8000_0000 size 4KB with R only, U-mode read of 0x8000_0010 accepted at edge t -> RspValid at t+2, MatchIndex=0, no faults.
REQ-043 Bench SHALL show: same setup with a U-mode write to 0x8000_0010 -> PMPStoreAmoAccessFault=1.
REQ-044 Bench SHALL show: entry 3 TOR with PMPAdr[2]=0x100 and PMPAdr[3]=0x200, RWX, and entries 0-2 OFF, S-mode read of 0x500 -> MatchIndex=3 at t+5, no fault.
REQ-045 Bench SHALL show: entry 0 NA4 at 0x1000 (PMPAdr=0x400), RW, U-mode 8-byte load at 0x0FFC -> AllBytesMatch=0 -> PMPLoadAccessFault=1.
REQ-046 Bench SHALL show: all entries OFF -> M-mode execute gives no fault at t+PMP_ENTRIES+1 with MatchValid=0, and U-mode execute gives PMPInstrAccessFault=0; then entry 15 set to NA4 -> U-mode execute faults.
REQ-047 Bench SHALL show: Flush at SCAN Idx=2 -> no RspValid and ReqReady=1 the next cycle; RspReady held low for 10 cycles -> outputs stable throughout.
